lcd_pattern_gen: RTL

- Pixel-data stage fed by the LCD timing generator's DE/HSYNC/VSYNC.
- Tracks active-area x/y from the incoming timing and renders one of four selectable RGB565 test patterns.
- Drives the panel pins with syncs and DE delayed to stay aligned with the generated colour.
- Replaces hard-wired colour-bar logic in the timing block; the timing block keeps timing only.

---
 rtl/lcd_pattern_gen.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen
//   Pixel-data stage that follows the LCD timing generator. It tracks the
//   active-area x/y position from the incoming DE/HSYNC/VSYNC, renders one of
//   four RGB565 test patterns and drives the panel pins. Syncs and DE are
//   delayed through the same two register stages as the colour, so every
//   output edge lags its input edge by exactly two PixelClk cycles.
//
//   Optional build macro: LCD_PATGEN_BORDER_EN
//     When defined, the outermost active row/column is forced white over any
//     pattern. The forcing is done in stage 2, so latency does not change.
//
// Ports
//   PixelClk     in   pixel clock
//   nRST         in   asynchronous active-low reset
//   in_de        in   data enable from timing generator (active-high)
//   in_hsync     in   hsync from timing generator (active-low)
//   in_vsync     in   vsync from timing generator (active-low)
//   pattern_sel  in   0 colour bars, 1 checkerboard, 2 gradient, 3 moving bar
//   LCD_DE       out  delayed in_de
//   LCD_HSYNC    out  delayed in_hsync
//   LCD_VSYNC    out  delayed in_vsync
//   LCD_R/G/B    out  RGB565 colour, zero while LCD_DE is low
//   frame_cnt    out  frames since reset, wraps 255 -> 0
module lcd_pattern_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 480,
  parameter int CHECK_LOG2 = 5,
  parameter int BAR_W      = 16,
  parameter int BAR_STEP   = 4
) (
  input  logic       PixelClk,
  input  logic       nRST,
  input  logic       in_de,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic [1:0] pattern_sel,
  output logic       LCD_DE,
  output logic       LCD_HSYNC,
  output logic       LCD_VSYNC,
  output logic [4:0] LCD_R,
  output logic [5:0] LCD_G,
  output logic [4:0] LCD_B,
  output logic [7:0] frame_cnt
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  localparam logic [15:0] C_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_CYAN    = 16'h07FF;
  localparam logic [15:0] C_GREEN   = 16'h07E0;
  localparam logic [15:0] C_MAGENTA = 16'hF81F;
  localparam logic [15:0] C_RED     = 16'hF800;
  localparam logic [15:0] C_BLUE    = 16'h001F;
  localparam logic [15:0] C_BLACK   = 16'h0000;

  // Colour-bar palette lookup, index 0 (left) .. 7 (right).
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = C_WHITE;
      3'd1:    c = C_YELLOW;
      3'd2:    c = C_CYAN;
      3'd3:    c = C_GREEN;
      3'd4:    c = C_MAGENTA;
      3'd5:    c = C_RED;
      3'd6:    c = C_BLUE;
      3'd7:    c = C_BLACK;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

  // Position tracking and frame state
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic          de_d_r;
  logic          vs_d_r;
  logic [7:0]    frame_cnt_r;
  logic [1:0]    pat_r;
  logic [XW-1:0] pos_r;

  // Stage 1
  logic [XW-1:0] s1_x_r;
  logic [YW-1:0] s1_y_r;
  logic          s1_de_r;
  logic          s1_hs_r;
  logic          s1_vs_r;

  // Combinational helpers
  logic          vs_fall_s;
  logic          de_fall_s;
  logic [XW:0]   pos_sum_s;
  logic [XW-1:0] pos_next_s;
  logic [15:0]   xe_s;
  logic [15:0]   ye_s;
  logic [2:0]    bar_idx_s;
  logic [15:0]   pat_colour_s;
  logic [15:0]   colour_s;

  assign vs_fall_s = vs_d_r & ~in_vsync;
  assign de_fall_s = de_d_r & ~in_de;
  assign frame_cnt = frame_cnt_r;

  // Bar position for the next frame; the bar wraps to the left edge once it
  // would start at or past the end of the line.
  always_comb begin
    pos_sum_s  = {1'b0, pos_r} + (XW+1)'(BAR_STEP);
    pos_next_s = pos_r;
    if (pos_sum_s >= (XW+1)'(H_ACTIVE)) begin
      pos_next_s = XW'(pos_sum_s - (XW+1)'(H_ACTIVE));
    end else begin
      pos_next_s = XW'(pos_sum_s);
    end
  end

  // Edge history, x/y counters and frame-boundary state.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      x_r         <= {XW{1'b0}};
      y_r         <= {YW{1'b0}};
      de_d_r      <= 1'b0;
      vs_d_r      <= 1'b1;
      frame_cnt_r <= 8'd0;
      pat_r       <= 2'd0;
      pos_r       <= {XW{1'b0}};
    end else begin
      de_d_r <= in_de;
      vs_d_r <= in_vsync;

      // x is the column of the pixel currently on the input; it saturates so
      // an over-long DE repeats the last column.
      if (in_de) begin
        if (x_r != XW'(H_ACTIVE - 1)) begin
          x_r <= x_r + XW'(1);
        end else begin
          x_r <= x_r;
        end
      end else begin
        x_r <= {XW{1'b0}};
      end

      // vsync fall restarts the frame and overrides an end-of-line step.
      if (vs_fall_s) begin
        y_r <= {YW{1'b0}};
      end else if (de_fall_s && (y_r != YW'(V_ACTIVE - 1))) begin
        y_r <= y_r + YW'(1);
      end else begin
        y_r <= y_r;
      end

      if (vs_fall_s) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
        pat_r       <= pattern_sel;
        pos_r       <= pos_next_s;
      end else begin
        frame_cnt_r <= frame_cnt_r;
        pat_r       <= pat_r;
        pos_r       <= pos_r;
      end
    end
  end

  // Stage 1: capture position and timing of the current input pixel.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      s1_x_r  <= {XW{1'b0}};
      s1_y_r  <= {YW{1'b0}};
      s1_de_r <= 1'b0;
      s1_hs_r <= 1'b1;
      s1_vs_r <= 1'b1;
    end else begin
      s1_x_r  <= x_r;
      s1_y_r  <= y_r;
      s1_de_r <= in_de;
      s1_hs_r <= in_hsync;
      s1_vs_r <= in_vsync;
    end
  end

  // Pattern rendering from the stage-1 position. Coordinates are widened so
  // bit selects above the counter width read as zero.
  always_comb begin
    xe_s         = 16'(s1_x_r);
    ye_s         = 16'(s1_y_r);
    bar_idx_s    = 3'd0;
    pat_colour_s = C_BLACK;
    for (int k = 1; k < 8; k++) begin
      if (xe_s >= 16'(k * H_ACTIVE / 8)) begin
        bar_idx_s = bar_idx_s + 3'd1;
      end else begin
        bar_idx_s = bar_idx_s;
      end
    end
    case (pat_r)
      2'd0: pat_colour_s = bar_colour(bar_idx_s);
      // Square containing the origin is white.
      2'd1: pat_colour_s = (xe_s[CHECK_LOG2] ^ ye_s[CHECK_LOG2]) ? C_BLACK : C_WHITE;
      2'd2: pat_colour_s = {xe_s[9:5], ye_s[8:3], ~xe_s[9:5]};
      // Compared at full width with no wrap, so the bar clips at the right edge.
      2'd3: pat_colour_s = ((xe_s >= 16'(pos_r)) && (xe_s < (16'(pos_r) + 16'(BAR_W))))
                           ? C_WHITE : C_BLACK;
      default: pat_colour_s = C_BLACK;
    endcase
  end

`ifdef LCD_PATGEN_BORDER_EN
  // Outermost active row/column forced white over the pattern.
  always_comb begin
    colour_s = pat_colour_s;
    if ((s1_x_r == {XW{1'b0}}) || (s1_x_r == XW'(H_ACTIVE - 1)) ||
        (s1_y_r == {YW{1'b0}}) || (s1_y_r == YW'(V_ACTIVE - 1))) begin
      colour_s = C_WHITE;
    end else begin
      colour_s = pat_colour_s;
    end
  end
`else
  assign colour_s = pat_colour_s;
`endif

  // Stage 2: panel pins; colour blanked whenever the delayed DE is low.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      LCD_DE    <= 1'b0;
      LCD_HSYNC <= 1'b1;
      LCD_VSYNC <= 1'b1;
      LCD_R     <= 5'd0;
      LCD_G     <= 6'd0;
      LCD_B     <= 5'd0;
    end else begin
      LCD_DE    <= s1_de_r;
      LCD_HSYNC <= s1_hs_r;
      LCD_VSYNC <= s1_vs_r;
      if (s1_de_r) begin
        LCD_R <= colour_s[15:11];
        LCD_G <= colour_s[10:5];
        LCD_B <= colour_s[4:0];
      end else begin
        LCD_R <= 5'd0;
        LCD_G <= 6'd0;
        LCD_B <= 5'd0;
      end
    end
  end

endmodule
